mem_lsu_ctrl: RTL
=================

# mem_lsu_ctrl

Memory-stage load/store controller for the 5-stage RV32I pipeline, sitting between the EX/MEM register and the MEM/WB register. It turns the MEM-stage access (address, store data, size) into a single-outstanding request/acknowledge transaction on the data-memory port. It holds the pipeline with a stall request until the memory acknowledges or a timeout fires. It then presents right-aligned load data to the MEM/WB register; sign/zero extension stays in WB.

## Interface
Parameters:
- TIMEOUT_CYC, default 16: REQ cycles without acknowledge before a bus error; legal range 2..255.

Ports:
- i_clk  in  1  pipeline clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_addr_MEM  in  32  byte address (ALU result).
- i_store_data_MEM  in  32  rs2 value for stores.
- i_funct3_MEM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_mem_rden_MEM  in  1  load in MEM.
- i_mem_wren_MEM  in  1  store in MEM; never high together with rden.
- i_stall_MEM  in  1  downstream hold (MEM/WB register stalled).
- o_dmem_req  out  1  request valid (registered).
- o_dmem_we  out  1  write enable (registered).
- o_dmem_addr  out  32  word address, bits [1:0] forced to 0 (registered).
- o_dmem_wdata  out  32  lane-replicated store data (registered).
- o_dmem_bmask  out  4  byte-enable mask (registered).
- i_dmem_ack  in  1  one-cycle acknowledge; rdata valid in the same cycle.
- i_dmem_rdata  in  32  read word.
- o_lsu_data  out  32  load data shifted to bit 0, unextended.
- o_stall_req  out  1  stall IF/ID/EX/MEM.
- o_misaligned  out  1  misaligned access (combinational, no request).
- o_bus_err  out  1  timeout on the current access.

## Operation
- States IDLE, REQ, DONE.
- Access condition: (rden|wren) & !misaligned.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.

State transitions:
- IDLE to REQ on the access condition. At the same edge, latch the word address, we, bmask, wdata and addr[1:0], and set o_dmem_req.
- REQ to DONE on i_dmem_ack. Capture the aligned rdata into o_lsu_data (0 for stores) and clear o_dmem_req.
- REQ to DONE when the timeout counter reaches TIMEOUT_CYC-1 without ack. Clear the request, set o_lsu_data=0 and o_bus_err=1.
- DONE to IDLE when i_stall_MEM=0. Otherwise DONE holds and o_lsu_data and o_bus_err stay stable.

Signal rules:
- o_stall_req = (IDLE & access condition) | REQ. It is low in DONE.
- o_misaligned is high in IDLE while a misaligned access is present. No request is issued, no stall is raised, and the instruction passes with o_lsu_data=0.
- Store mask and data:
  - SB: bmask = 1<<off, wdata = {4{rs2[7:0]}}.
  - SH: bmask = 0011<<off, wdata = {2{rs2[15:0]}}.
  - SW: bmask = 1111, wdata = rs2.
  - Loads: bmask = 1111, we = 0.
- Load align: o_lsu_data = rdata >> (8*off). Upper bits are don't-care-free: they carry the shifted word, and WB masks/extends them.
- Timeout counter is 8 bits, cleared on entering REQ, incrementing each REQ cycle.
- An ack in IDLE or DONE (spurious) is ignored.

## Timing
- Reset (i_rst=0, asynchronous): state IDLE, counter 0, and every registered output at 0 (o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_bmask, o_lsu_data, o_bus_err). Combinational outputs follow the inputs in IDLE.
- Access presented in cycle T: req is high from T+1. With ack in cycle A ≥ T+1, DONE is cycle A+1. The instruction leaves MEM at the end of A+1 with no downstream stall.
- Minimum MEM occupancy is 3 cycles; the MEM/WB register samples o_lsu_data at the end of DONE.
- o_dmem_req stays high continuously from entry into REQ until the ack or timeout edge. It is never re-pulsed for the same access.
- Reset asserted in REQ drops req immediately (asynchronously). An in-flight ack after reset release is ignored.
- Ack and timeout in the same cycle: the ack wins, o_bus_err=0.

## Structure
- Shared package lsu_pkg holds:
  - the state enum (lsu_state_e);
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- The codebase's parameterised dff is not used because of asynchronous active-low reset semantics.
- Sub-module lsu_align (combinational): computes misaligned, bmask and wdata from funct3/off/rs2, and aligned rdata from rdata/off. The FSM, counter and registers stay in mem_lsu_ctrl.

## Test plan
- LW at 0x100, ack one cycle after req, rdata 0xDEADBEEF -> req high 1 cycle, addr 0x100, stall high 2 cycles, o_lsu_data=0xDEADBEEF in DONE.
- SB rs2=0x000000A5 at 0x203 -> addr 0x200, bmask 1000, wdata 0xA5A5A5A5, we=1. Then SH at 0x202 -> bmask 1100.
- LH at 0x101 -> o_misaligned=1, o_dmem_req never rises, o_stall_req=0.
- LW with no ack, TIMEOUT_CYC=4 -> req high exactly 4 cycles, then DONE with o_bus_err=1, o_lsu_data=0.
- LBU at 0x302, rdata 0x11223344, ack in the same cycle as i_stall_MEM=1 for 3 cycles -> DONE held 3 cycles, o_lsu_data=0x00001122 stable throughout.
- Reset pulsed mid-REQ, then a late ack -> req drops asynchronously, FSM stays IDLE, all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store controller.
package lsu_pkg;

    // Controller states: waiting for an access, request outstanding, result held for MEM/WB.
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // RV32I funct3 encodings for loads/stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Access width from funct3; unused encodings fall back to word.
    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: alignment check, store mask/data replication,
// and right-alignment of the returned read word. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  acc_off,     // offset of the access being presented
    input  logic [31:0] rs2,
    input  logic [1:0]  rd_off,      // offset latched for the outstanding load
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  st_bmask,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    // Size-dependent mask, replicated store data and alignment fault.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave one unassigned (no latch).
        misaligned = 1'b0;
        st_bmask   = 4'b1111;
        st_wdata   = rs2;
        case (size_of(funct3))
            SZ_BYTE: begin
                st_bmask = 4'b0001 << acc_off;
                st_wdata = {4{rs2[7:0]}};
            end
            SZ_HALF: begin
                misaligned = acc_off[0];
                st_bmask   = 4'b0011 << acc_off;
                st_wdata   = {2{rs2[15:0]}};
            end
            default: begin
                misaligned = (acc_off != 2'b00);
            end
        endcase
    end

    // Shift the addressed byte down to bit 0; extension happens in WB.
    assign ld_data = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store controller: one outstanding req/ack access on the data
// port, pipeline stall while it is in flight, timeout to bus error, and
// right-aligned load data held for the MEM/WB register.
module mem_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr_MEM,
    input  logic [31:0] i_store_data_MEM,
    input  logic [2:0]  i_funct3_MEM,
    input  logic        i_mem_rden_MEM,
    input  logic        i_mem_wren_MEM,
    input  logic        i_stall_MEM,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_lsu_data,
    output logic        o_stall_req,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    lsu_state_e  state;
    logic [7:0]  tmo_cnt;
    logic [1:0]  off_q;

    logic        mem_acc;
    logic        mis_raw;
    logic        access;
    logic [3:0]  st_bmask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    lsu_align u_align (
        .funct3     (i_funct3_MEM),
        .acc_off    (i_addr_MEM[1:0]),
        .rs2        (i_store_data_MEM),
        .rd_off     (off_q),
        .rdata      (i_dmem_rdata),
        .misaligned (mis_raw),
        .st_bmask   (st_bmask),
        .st_wdata   (st_wdata),
        .ld_data    (ld_data)
    );

    assign mem_acc      = i_mem_rden_MEM | i_mem_wren_MEM;
    assign access       = mem_acc & ~mis_raw;
    assign o_misaligned = (state == LSU_IDLE) & mem_acc & mis_raw;
    assign o_stall_req  = ((state == LSU_IDLE) & access) | (state == LSU_REQ);

    // Access FSM with timeout counter and all registered data-port/result outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            state        <= LSU_IDLE;
            tmo_cnt      <= 8'd0;
            off_q        <= 2'd0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_bmask <= 4'd0;
            o_lsu_data   <= 32'd0;
            o_bus_err    <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (access) begin
                        state        <= LSU_REQ;
                        tmo_cnt      <= 8'd0;
                        off_q        <= i_addr_MEM[1:0];
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= i_mem_wren_MEM;
                        o_dmem_addr  <= {i_addr_MEM[31:2], 2'b00};
                        o_dmem_wdata <= st_wdata;
                        o_dmem_bmask <= i_mem_wren_MEM ? st_bmask : 4'b1111;
                    end
                end
                LSU_REQ: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (i_dmem_ack) begin
                        state      <= LSU_DONE;
                        o_dmem_req <= 1'b0;
                        o_lsu_data <= o_dmem_we ? 32'd0 : ld_data;
                        o_bus_err  <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= LSU_DONE;
                        o_dmem_req <= 1'b0;
                        o_lsu_data <= 32'd0;
                        o_bus_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                LSU_DONE: begin
                    // Result stays put until MEM/WB is free to take it.
                    if (!i_stall_MEM) begin
                        state      <= LSU_IDLE;
                        o_lsu_data <= 32'd0;
                        o_bus_err  <= 1'b0;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule
